// File: rtl/clock_tap_select.sv
// Glitch-free run-time selector between the /2, /4 and /8 divider taps.
// A switch drains the old tap's high phase, then waits for the new tap to go low.
module clock_tap_select #(
    parameter int         CNT_W     = 16,
    parameter logic [1:0] RESET_SEL = 2'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       div_in,
    input  logic [1:0]       sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             clk_out,
    output logic             rise_strobe,
    output logic [1:0]       active_sel,
    output logic             busy,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN_OLD,
        FILL_NEW
    } state_t;

    state_t     state;
    logic [1:0] pending_sel;
    logic       active_tap;
    logic       clk_next;

    // Encoding 3 means "off": the tap reads as a constant 0.
    function automatic logic tap_of(input logic [2:0] taps, input logic [1:0] s);
        case (s)
            2'd0:    return taps[0];
            2'd1:    return taps[1];
            2'd2:    return taps[2];
            default: return 1'b0;
        endcase
    endfunction

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        active_tap = tap_of(div_in, active_sel);
        clk_next   = (state == FILL_NEW) ? 1'b0 : active_tap;
    end

    assign sel_ready = (state == RUN);
    assign busy      = ~sel_ready;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            active_sel  <= RESET_SEL;
            pending_sel <= RESET_SEL;
            clk_out     <= 1'b0;
            rise_strobe <= 1'b0;
            edge_count  <= '0;
        end else begin
            clk_out     <= clk_next;
            rise_strobe <= clk_next & ~clk_out;
            edge_count  <= edge_count + CNT_W'(rise_strobe);

            case (state)
                RUN: begin
                    if (sel_valid && (sel != active_sel)) begin
                        pending_sel <= sel;
                        state       <= DRAIN_OLD;
                    end
                end
                DRAIN_OLD: begin
                    // A low sample means the old high phase has fully ended.
                    if (!active_tap) begin
                        active_sel <= pending_sel;
                        state      <= FILL_NEW;
                    end
                end
                FILL_NEW: begin
                    // Resume only from a low sample so the first high phase is complete.
                    if (!active_tap) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_tap_select.sv
// Directed bench for clock_tap_select driven by a free-running 3-bit divider counter.
// Expected values are hand-derived per step; step k samples the counter value k-1.
module tb_clock_tap_select;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       div_in;
    logic [1:0]       sel;
    logic             sel_valid;
    logic             sel_ready;
    logic             clk_out;
    logic             rise_strobe;
    logic [1:0]       active_sel;
    logic             busy;
    logic [CNT_W-1:0] edge_count;

    logic [2:0] cnt;
    int n_cmp  = 0;
    int n_fail = 0;

    clock_tap_select #(.CNT_W(CNT_W), .RESET_SEL(2'd0)) dut (
        .clock       (clock),
        .reset       (reset),
        .div_in      (div_in),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .clk_out     (clk_out),
        .rise_strobe (rise_strobe),
        .active_sel  (active_sel),
        .busy        (busy),
        .edge_count  (edge_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the upstream counter; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cnt    = cnt + 3'd1;
        div_in = cnt;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " clk_out"},     clk_out,     0);
        check({tag, " rise_strobe"}, rise_strobe, 0);
        check({tag, " edge_count"},  edge_count,  0);
        check({tag, " sel_ready"},   sel_ready,   1);
        check({tag, " busy"},        busy,        0);
        check({tag, " active_sel"},  active_sel,  0);
    endtask

    logic [8:0] exp_free;
    logic [4:0] exp_hi8;
    logic [7:0] exp_q4_clk;
    logic [7:0] exp_q4_stb;

    initial begin
        reset     = 1'b0;
        cnt       = 3'd0;
        div_in    = 3'd0;
        sel       = 2'd0;
        sel_valid = 1'b0;

        // Reset and free run on the /2 tap
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        check_reset_state("reset");
        exp_free = 9'b010101010;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("free clk_out", clk_out, exp_free[k-1]);
            check("free rise_strobe", rise_strobe, exp_free[k-1]);
        end
        check("free edge_count", edge_count, 4);

        // Switch /2 -> /8 while div_in[0]=1
        sel       = 2'd2;
        sel_valid = 1'b1;
        step();
        check("drain clk_out", clk_out, 1);
        check("drain rise_strobe", rise_strobe, 1);
        check("drain busy", busy, 1);
        check("drain sel_ready", sel_ready, 0);
        check("drain active_sel", active_sel, 0);

        // Request during busy must be ignored
        sel = 2'd1;
        step();
        check("fill clk_out", clk_out, 0);
        check("fill active_sel", active_sel, 2);
        check("fill busy", busy, 1);
        check("fill edge_count", edge_count, 5);
        step();
        check("rerun clk_out", clk_out, 0);
        check("rerun busy", busy, 0);
        check("rerun active_sel", active_sel, 2);
        sel_valid = 1'b0;

        exp_hi8 = 5'b01111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("div8 clk_out", clk_out, exp_hi8[k]);
            check("div8 rise_strobe", rise_strobe, (k == 0) ? 1 : 0);
        end
        check("div8 active_sel", active_sel, 2);

        // Same-tap request is a no-op
        sel       = 2'd2;
        sel_valid = 1'b1;
        step();
        check("same sel_ready", sel_ready, 1);
        check("same busy", busy, 0);
        check("same active_sel", active_sel, 2);
        check("same clk_out", clk_out, 0);
        sel_valid = 1'b0;
        repeat (2) step();
        step();
        check("same rise clk_out", clk_out, 1);
        check("same rise_strobe", rise_strobe, 1);
        repeat (4) step();
        check("same low clk_out", clk_out, 0);

        // Off and back to /4
        sel       = 2'd3;
        sel_valid = 1'b1;
        step();
        check("off drain busy", busy, 1);
        check("off drain clk_out", clk_out, 0);
        sel_valid = 1'b0;
        step();
        check("off fill active_sel", active_sel, 3);
        step();
        check("off run busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("off clk_out", clk_out, 0);
            check("off rise_strobe", rise_strobe, 0);
        end

        sel       = 2'd1;
        sel_valid = 1'b1;
        step();
        check("on drain busy", busy, 1);
        sel_valid = 1'b0;
        step();
        check("on fill active_sel", active_sel, 1);
        check("on fill clk_out", clk_out, 0);
        step();
        check("on run busy", busy, 0);
        exp_q4_clk = 8'b01100110;
        exp_q4_stb = 8'b00100010;
        for (int k = 0; k < 8; k++) begin
            step();
            check("div4 clk_out", clk_out, exp_q4_clk[k]);
            check("div4 rise_strobe", rise_strobe, exp_q4_stb[k]);
        end

        // /4 -> /8, then reset while in FILL_NEW
        sel       = 2'd2;
        sel_valid = 1'b1;
        step();
        check("mid drain busy", busy, 1);
        check("mid drain clk_out", clk_out, 0);
        sel_valid = 1'b0;
        step();
        check("mid old high clk_out", clk_out, 1);
        check("mid old high strobe", rise_strobe, 1);
        check("mid old high active_sel", active_sel, 1);
        step();
        check("mid old high2 clk_out", clk_out, 1);
        step();
        check("mid fill clk_out", clk_out, 0);
        check("mid fill active_sel", active_sel, 2);
        step();
        check("mid fill hold busy", busy, 1);
        check("mid fill hold clk_out", clk_out, 0);
        check("mid edge_count", edge_count, 10);

        #1;
        reset = 1'b0;
        #1;
        check_reset_state("midreset");

        // Release and count 17 /2 edges through the 4-bit wrap
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cnt    = 3'd0;
        div_in = 3'd0;
        check("post active_sel", active_sel, 0);
        for (int k = 1; k <= 35; k++) begin
            step();
            check("wrap clk_out", clk_out, (k % 2 == 0) ? 1 : 0);
            if (k == 31) check("wrap edge_count 15", edge_count, 15);
            if (k == 33) check("wrap edge_count 0", edge_count, 0);
            if (k == 35) check("wrap edge_count 1", edge_count, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
